fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode/execute core. It walks the program counter, issues word fetches to instruction memory over a request/response interface, and buffers returned instructions with their PCs. It presents them to the core through a valid/ready port. On a redirect from the core (taken branch or jump) it flushes the buffer, discards stale in-flight responses and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC and the {pc, instr}
// entry handed from fetch to decode.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 4;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous flush; flush wins over push and pop.
// Used both as the in-flight PC queue and as the instruction buffer.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which words are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks the PC, keeps at most DEPTH fetches buffered or in
// flight, and drops stale responses after a redirect from the core.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop;

    logic [CNT_W:0]     inflight;
    logic               req_valid;
    logic               req_fire;
    logic               rsp_live;
    logic               rsp_drop;
    logic               out_fire;

    logic [ADDR_W-1:0]  pcq_head;
    logic               pcq_full;
    logic               pcq_empty;
    logic [CNT_W-1:0]   pcq_count;

    logic [ENTRY_W-1:0] buf_head;
    logic               buf_full;
    logic               buf_empty;
    logic [CNT_W-1:0]   buf_count;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        inflight  = '0;
        req_valid = 1'b0;
        req_fire  = 1'b0;
        rsp_live  = 1'b0;
        rsp_drop  = 1'b0;
        out_fire  = 1'b0;

        inflight  = {1'b0, buf_count} + {1'b0, outstanding};
        // Gated by rst_n so no request is visible while the memory side is held in reset.
        req_valid = rst_n && !redirect_valid && (inflight < (CNT_W+1)'(DEPTH));
        req_fire  = req_valid && imem_req_ready;
        rsp_drop  = imem_rsp_valid && (redirect_valid || (drop != '0));
        rsp_live  = imem_rsp_valid && !redirect_valid && (drop == '0);
        out_fire  = !buf_empty && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight becomes stale, including earlier drops.
                fetch_pc <= redirect_pc;
                drop     <= outstanding - CNT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(1);
                if (rsp_drop) drop     <= drop - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_live),
        .pop_data  (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_live),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (out_fire),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = fetch_pc;
    assign out_valid      = !buf_empty;
    assign out_pc         = buf_head[ENTRY_W-1 -: ADDR_W];
    assign out_instr      = buf_head[DATA_W-1:0];

    // The issue rule reserves buffer space for every live fetch.
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_live && buf_full && !out_fire));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_fire && pcq_full));
    a_pcq_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_live && pcq_empty));
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding == '0)));
    a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
        (pcq_count == outstanding - drop) || (drop > outstanding));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model plus an
// expected-entry queue drained by an independent output monitor.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } mem_req_t;

    mem_req_t     mq[$];
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    // Memory: responds in order exactly lat cycles after each request handshake.
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        mem_req_t r;
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            r.due  = cyc + lat;
            r.addr = imem_req_addr;
            mq.push_back(r);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_fn(pc);
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got pc 0x%0h expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(e.pc));
                    check("sb_instr", 64'(out_instr), 64'(e.instr));
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        tcyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tcyc  = 0;
    endtask

    // Holds out_ready high until n handshakes, bounded; reports first/last handshake cycle
    // and the first request address seen.
    task automatic consume(input int n, output int first, output int last, output int req_addr);
        int got;
        got      = 0;
        first    = -1;
        last     = -1;
        req_addr = -1;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                next_cycle();
                #1;
            end
            if (req_addr < 0 && imem_req_valid) req_addr = int'(imem_req_addr);
            if (out_valid && out_ready) begin
                if (first < 0) first = tcyc;
                last = tcyc;
                got++;
            end
            if (got == n) break;
        end
        next_cycle();
        out_ready = 1'b0;
        check("consume_count", 64'(got), 64'(n));
    endtask

    initial begin
        int f, l, ra, nreq;

        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not reach the end");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", 64'(imem_req_addr), 64'h0000);

        // L=1 streaming: first handshake two cycles after the first request, then 1/cycle
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) expect_pc(16'(i));
        consume(8, f, l, ra);
        check("l1_first_req_addr", 64'(ra), 64'd0);
        check("l1_first_out_cycle", 64'(f), 64'd2);
        check("l1_last_out_cycle", 64'(l), 64'd9);
        check("l1_drain", 64'(exp_q.size()), 64'd0);

        // Stall: req_ready low for two cycles, then out_ready low caps in-flight at 4
        lat  = 1;
        do_reset();
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            imem_req_ready = (tcyc >= 2);
            #1;
            if (tcyc == 2) check("stall_held_addr", 64'(imem_req_addr), 64'h0000);
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        check("stall_req_count", 64'(nreq), 64'd4);
        check("stall_req_blocked", 64'(imem_req_valid), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        next_cycle();
        for (int i = 0; i < 4; i++) expect_pc(16'(i));
        consume(4, f, l, ra);
        check("stall_resume_pc", 64'(ra), 64'd4);
        check("stall_first_out", 64'(f), 64'd10);
        check("stall_drain", 64'(exp_q.size()), 64'd0);

        // L=3 redirect at cycle 3 with 3 outstanding: all stale data dropped
        lat = 3;
        do_reset();
        repeat (3) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        out_ready      = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(16'h0040 + 16'(i));
        #1;
        check("l3_redir_req_blocked", 64'(imem_req_valid), 64'd0);
        check("l3_redir_out_valid", 64'(out_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("l3_new_req_valid", 64'(imem_req_valid), 64'd1);
        check("l3_new_req_addr", 64'(imem_req_addr), 64'h0040);
        check("l3_out_still_empty", 64'(out_valid), 64'd0);
        next_cycle();
        consume(4, f, l, ra);
        check("l3_first_new_out", 64'(f), 64'd8);
        check("l3_last_new_out", 64'(l), 64'd11);
        check("l3_second_req_addr", 64'(ra), 64'h0041);
        check("l3_drain", 64'(exp_q.size()), 64'd0);

        // Redirect coinciding with a response and an out handshake
        lat = 1;
        do_reset();
        out_ready = 1'b1;
        expect_pc(16'h0000);
        expect_pc(16'h0001);
        expect_pc(16'h0002);
        expect_pc(16'h0100);
        expect_pc(16'h0101);
        repeat (4) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        check("mix_req_blocked", 64'(imem_req_valid), 64'd0);
        check("mix_pop_valid", 64'(out_valid), 64'd1);
        check("mix_pop_pc", 64'(out_pc), 64'h0002);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("mix_flushed", 64'(out_valid), 64'd0);
        check("mix_new_req_addr", 64'(imem_req_addr), 64'h0100);
        next_cycle();
        consume(2, f, l, ra);
        check("mix_first_new_out", 64'(f), 64'd7);
        check("mix_last_new_out", 64'(l), 64'd8);
        check("mix_req_addr", 64'(ra), 64'h0101);
        check("mix_drain", 64'(exp_q.size()), 64'd0);

        // PC wrap through 0xFFFF
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        #1;
        check("wrap_redir_blocked", 64'(imem_req_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("wrap_req_addr", 64'(imem_req_addr), 64'hFFFE);
        next_cycle();
        expect_pc(16'hFFFE);
        expect_pc(16'hFFFF);
        expect_pc(16'h0000);
        expect_pc(16'h0001);
        consume(4, f, l, ra);
        check("wrap_req_after", 64'(ra), 64'hFFFF);
        check("wrap_first_out", 64'(f), 64'd3);
        check("wrap_last_out", 64'(l), 64'd6);
        check("wrap_drain", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with 2 outstanding
        lat = 2;
        do_reset();
        repeat (3) next_cycle();
        #1;
        check("mid_pre_reset_valid", 64'(out_valid), 64'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("mid_rst_req_addr", 64'(imem_req_addr), 64'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tcyc  = 0;
        for (int i = 0; i < 4; i++) expect_pc(16'(i));
        consume(4, f, l, ra);
        check("mid_restart_addr", 64'(ra), 64'h0000);
        check("mid_first_out", 64'(f), 64'd3);
        check("mid_last_out", 64'(l), 64'd6);
        check("mid_drain", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
